// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch/execute program-counter sequencer with ack timeout, halt and fault states
module pc_fetch_sequencer #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          ACK_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        Reset_L,
   output logic        IMemReq,
   output logic [63:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] Instruction,
   output logic        InstrValid,
   input  logic        ExecDone,
   input  logic        Branch,
   input  logic        Uncondbranch,
   input  logic        ALUZero,
   input  logic [63:0] SignExtImm64,
   input  logic        Halt,
   output logic [63:0] CurrentPC,
   output logic        Halted,
   output logic        Fault,
   output logic [31:0] RetireCount
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {FETCH, EXEC, HALTED, FAULT} state_t;
   state_t         state_q, state_d;
   logic [63:0]    pc_q, pc_d, next_pc;
   logic [31:0]    rc_q, rc_d, instr_q, instr_d;
   logic [TW-1:0]  to_q, to_d;
   logic           taken;
   // next-state logic: fetch handshake with timeout, retire on ExecDone, terminal HALTED/FAULT
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rc_d    = rc_q;
      instr_d = instr_q;
      to_d    = to_q;
      taken   = Uncondbranch | (Branch & ALUZero);
      next_pc = pc_q + (taken ? (SignExtImm64 << 2) : 64'd4);
      unique case (state_q)
         FETCH: begin
            if (pc_q[1:0] != 2'b00) state_d = FAULT;
            else if (IMemAck) begin
               instr_d = IMemData;
               to_d    = '0;
               state_d = EXEC;
            end else begin
               to_d = to_q + TW'(1);
               if (to_d == TW'(ACK_TIMEOUT)) state_d = FAULT;
            end
         end
         EXEC: begin
            if (ExecDone) begin
               pc_d    = next_pc;
               rc_d    = rc_q + 32'd1;
               state_d = Halt ? HALTED : FETCH;
            end
         end
         default: state_d = state_q;
      endcase
   end
   // state and datapath registers, asynchronously cleared
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         rc_q    <= '0;
         instr_q <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rc_q    <= rc_d;
         instr_q <= instr_d;
         to_q    <= to_d;
      end
   end
   assign IMemReq     = (state_q == FETCH) && (pc_q[1:0] == 2'b00);
   assign IMemAddr    = pc_q;
   assign CurrentPC   = pc_q;
   assign Instruction = instr_q;
   assign InstrValid  = (state_q == EXEC);
   assign Halted      = (state_q == HALTED);
   assign Fault       = (state_q == FAULT);
   assign RetireCount = rc_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed checks of fetch, branch, timeout, halt, misalignment and reset
module tb_pc_fetch_sequencer;
   logic        CLK = 0;
   logic        Reset_L = 1;
   logic        IMemAck = 0;
   logic [31:0] IMemData = 0;
   logic        ExecDone = 0, Branch = 0, Uncondbranch = 0, ALUZero = 0, Halt = 0;
   logic [63:0] SignExtImm64 = 0;
   logic        IMemReq, InstrValid, Halted, Fault;
   logic [63:0] IMemAddr, CurrentPC;
   logic [31:0] Instruction, RetireCount;
   logic        b_IMemReq, b_InstrValid, b_Halted, b_Fault;
   logic [63:0] b_IMemAddr, b_CurrentPC;
   logic [31:0] b_Instruction, b_RetireCount;
   int pass_cnt = 0;
   int total = 0;

   always #5 CLK = ~CLK;

   pc_fetch_sequencer #(.RESET_PC(64'h0), .ACK_TIMEOUT(4)) u0 (
      .CLK(CLK), .Reset_L(Reset_L), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemAck(IMemAck), .IMemData(IMemData), .Instruction(Instruction),
      .InstrValid(InstrValid), .ExecDone(ExecDone), .Branch(Branch),
      .Uncondbranch(Uncondbranch), .ALUZero(ALUZero), .SignExtImm64(SignExtImm64),
      .Halt(Halt), .CurrentPC(CurrentPC), .Halted(Halted), .Fault(Fault),
      .RetireCount(RetireCount));

   pc_fetch_sequencer #(.RESET_PC(64'h2)) u1 (
      .CLK(CLK), .Reset_L(Reset_L), .IMemReq(b_IMemReq), .IMemAddr(b_IMemAddr),
      .IMemAck(IMemAck), .IMemData(IMemData), .Instruction(b_Instruction),
      .InstrValid(b_InstrValid), .ExecDone(ExecDone), .Branch(Branch),
      .Uncondbranch(Uncondbranch), .ALUZero(ALUZero), .SignExtImm64(SignExtImm64),
      .Halt(Halt), .CurrentPC(b_CurrentPC), .Halted(b_Halted), .Fault(b_Fault),
      .RetireCount(b_RetireCount));

   task automatic apply_reset;
      @(negedge CLK);
      Reset_L = 0; IMemAck = 0; ExecDone = 0; Branch = 0; Uncondbranch = 0;
      ALUZero = 0; Halt = 0; SignExtImm64 = 0;
      @(negedge CLK);
      Reset_L = 1;
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] data);
      IMemAck = 1; IMemData = data;
      @(negedge CLK);
      IMemAck = 0;
      #1;
   endtask

   task automatic do_exec(input logic br, input logic ub, input logic z,
                          input logic [63:0] imm, input logic h);
      ExecDone = 1; Branch = br; Uncondbranch = ub; ALUZero = z; SignExtImm64 = imm; Halt = h;
      @(negedge CLK);
      ExecDone = 0; Branch = 0; Uncondbranch = 0; ALUZero = 0; SignExtImm64 = 0; Halt = 0;
      #1;
   endtask

   task automatic test_reset;
      @(negedge CLK);
      Reset_L = 0;
      #1;
      total++; if (CurrentPC !== 64'h0) $display("FAIL rst_pc: got %h exp %h", CurrentPC, 64'h0); else pass_cnt++;
      total++; if (RetireCount !== 32'h0) $display("FAIL rst_rc: got %h exp %h", RetireCount, 32'h0); else pass_cnt++;
      total++; if (Instruction !== 32'h0) $display("FAIL rst_instr: got %h exp %h", Instruction, 32'h0); else pass_cnt++;
      total++; if ({InstrValid, Halted, Fault} !== 3'b000) $display("FAIL rst_flags: got %b exp %b", {InstrValid, Halted, Fault}, 3'b000); else pass_cnt++;
      total++; if (b_CurrentPC !== 64'h2) $display("FAIL rst_pc_b: got %h exp %h", b_CurrentPC, 64'h2); else pass_cnt++;
      total++; if (b_Fault !== 1'b0) $display("FAIL rst_fault_b: got %b exp %b", b_Fault, 1'b0); else pass_cnt++;
      @(negedge CLK);
      Reset_L = 1;
      #1;
      total++; if (IMemReq !== 1'b1) $display("FAIL first_req: got %b exp %b", IMemReq, 1'b1); else pass_cnt++;
      total++; if (IMemAddr !== 64'h0) $display("FAIL first_addr: got %h exp %h", IMemAddr, 64'h0); else pass_cnt++;
      total++; if (b_IMemReq !== 1'b0) $display("FAIL misal_req0: got %b exp %b", b_IMemReq, 1'b0); else pass_cnt++;
      @(negedge CLK);
      #1;
      total++; if (b_Fault !== 1'b1) $display("FAIL misal_fault: got %b exp %b", b_Fault, 1'b1); else pass_cnt++;
      total++; if (b_IMemReq !== 1'b0) $display("FAIL misal_req1: got %b exp %b", b_IMemReq, 1'b0); else pass_cnt++;
      total++; if (b_CurrentPC !== 64'h2) $display("FAIL misal_pc: got %h exp %h", b_CurrentPC, 64'h2); else pass_cnt++;
   endtask

   task automatic test_sequential;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         total++; if (IMemAddr !== 64'(4 * i)) $display("FAIL seq_addr%0d: got %h exp %h", i, IMemAddr, 64'(4 * i)); else pass_cnt++;
         total++; if (IMemReq !== 1'b1) $display("FAIL seq_req%0d: got %b exp %b", i, IMemReq, 1'b1); else pass_cnt++;
         do_fetch(32'hA000 + 32'(i));
         total++; if (Instruction !== 32'hA000 + 32'(i)) $display("FAIL seq_instr%0d: got %h exp %h", i, Instruction, 32'hA000 + 32'(i)); else pass_cnt++;
         total++; if ({InstrValid, IMemReq} !== 2'b10) $display("FAIL seq_exec%0d: got %b exp %b", i, {InstrValid, IMemReq}, 2'b10); else pass_cnt++;
         do_exec(0, 0, 0, 64'h0, 0);
      end
      total++; if (IMemAddr !== 64'hC) $display("FAIL seq_addr3: got %h exp %h", IMemAddr, 64'hC); else pass_cnt++;
      total++; if (RetireCount !== 32'd3) $display("FAIL seq_rc: got %0d exp %0d", RetireCount, 3); else pass_cnt++;
   endtask

   task automatic test_ignore;
      ExecDone = 1;
      @(negedge CLK);
      ExecDone = 0;
      #1;
      total++; if (CurrentPC !== 64'hC) $display("FAIL ign_done_pc: got %h exp %h", CurrentPC, 64'hC); else pass_cnt++;
      total++; if (RetireCount !== 32'd3) $display("FAIL ign_done_rc: got %0d exp %0d", RetireCount, 3); else pass_cnt++;
      do_fetch(32'hBEEF);
      IMemAck = 1; IMemData = 32'h1234;
      @(negedge CLK);
      IMemAck = 0;
      #1;
      total++; if (Instruction !== 32'hBEEF) $display("FAIL ign_ack_instr: got %h exp %h", Instruction, 32'hBEEF); else pass_cnt++;
      total++; if (InstrValid !== 1'b1) $display("FAIL ign_ack_valid: got %b exp %b", InstrValid, 1'b1); else pass_cnt++;
      do_exec(0, 0, 0, 64'h0, 0);
      total++; if (CurrentPC !== 64'h10) $display("FAIL ign_next_pc: got %h exp %h", CurrentPC, 64'h10); else pass_cnt++;
   endtask

   task automatic test_cond_branch;
      apply_reset();
      do_fetch(32'h1); do_exec(0, 1, 0, 64'h40, 0);
      total++; if (CurrentPC !== 64'h100) $display("FAIL br_setup: got %h exp %h", CurrentPC, 64'h100); else pass_cnt++;
      do_fetch(32'h2); do_exec(1, 0, 1, -64'sd4, 0);
      total++; if (CurrentPC !== 64'hF0) $display("FAIL br_taken: got %h exp %h", CurrentPC, 64'hF0); else pass_cnt++;
      apply_reset();
      do_fetch(32'h1); do_exec(0, 1, 0, 64'h40, 0);
      do_fetch(32'h2); do_exec(1, 0, 0, -64'sd4, 0);
      total++; if (CurrentPC !== 64'h104) $display("FAIL br_not_taken: got %h exp %h", CurrentPC, 64'h104); else pass_cnt++;
   endtask

   task automatic test_uncond_branch;
      apply_reset();
      do_fetch(32'h1); do_exec(0, 1, 0, 64'h8, 0);
      total++; if (CurrentPC !== 64'h20) $display("FAIL ub_setup: got %h exp %h", CurrentPC, 64'h20); else pass_cnt++;
      do_fetch(32'h2); do_exec(0, 1, 0, 64'h3, 0);
      total++; if (CurrentPC !== 64'h2C) $display("FAIL ub_taken: got %h exp %h", CurrentPC, 64'h2C); else pass_cnt++;
      apply_reset();
      do_fetch(32'h3); do_exec(0, 1, 0, -64'sd1, 0);
      total++; if (CurrentPC !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL ub_wrap: got %h exp %h", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC); else pass_cnt++;
   endtask

   task automatic test_timeout;
      apply_reset();
      repeat (3) @(negedge CLK);
      #1;
      total++; if ({Fault, IMemReq} !== 2'b01) $display("FAIL to_before: got %b exp %b", {Fault, IMemReq}, 2'b01); else pass_cnt++;
      @(negedge CLK);
      #1;
      total++; if ({Fault, IMemReq} !== 2'b10) $display("FAIL to_fault: got %b exp %b", {Fault, IMemReq}, 2'b10); else pass_cnt++;
      IMemAck = 1; ExecDone = 1;
      repeat (3) @(negedge CLK);
      IMemAck = 0; ExecDone = 0;
      #1;
      total++; if ({Fault, IMemReq, InstrValid} !== 3'b100) $display("FAIL to_hold: got %b exp %b", {Fault, IMemReq, InstrValid}, 3'b100); else pass_cnt++;
      total++; if (CurrentPC !== 64'h0) $display("FAIL to_pc: got %h exp %h", CurrentPC, 64'h0); else pass_cnt++;
   endtask

   task automatic test_halt;
      apply_reset();
      do_fetch(32'h1); do_exec(0, 0, 0, 64'h0, 0);
      do_fetch(32'h2); do_exec(0, 0, 0, 64'h0, 0);
      total++; if (CurrentPC !== 64'h8) $display("FAIL halt_setup: got %h exp %h", CurrentPC, 64'h8); else pass_cnt++;
      do_fetch(32'h3); do_exec(0, 0, 0, 64'h0, 1);
      total++; if ({Halted, Fault, InstrValid} !== 3'b100) $display("FAIL halt_flags: got %b exp %b", {Halted, Fault, InstrValid}, 3'b100); else pass_cnt++;
      total++; if (CurrentPC !== 64'hC) $display("FAIL halt_pc: got %h exp %h", CurrentPC, 64'hC); else pass_cnt++;
      IMemAck = 1; ExecDone = 1;
      for (int i = 0; i < 3; i++) begin
         total++; if (IMemReq !== 1'b0) $display("FAIL halt_req%0d: got %b exp %b", i, IMemReq, 1'b0); else pass_cnt++;
         @(negedge CLK);
         #1;
      end
      IMemAck = 0; ExecDone = 0;
      total++; if (CurrentPC !== 64'hC) $display("FAIL halt_hold_pc: got %h exp %h", CurrentPC, 64'hC); else pass_cnt++;
      total++; if (RetireCount !== 32'd3) $display("FAIL halt_rc: got %0d exp %0d", RetireCount, 3); else pass_cnt++;
   endtask

   task automatic test_reset_exec;
      apply_reset();
      do_fetch(32'h1); do_exec(0, 0, 0, 64'h0, 0);
      do_fetch(32'h2);
      total++; if ({InstrValid, RetireCount} !== {1'b1, 32'd1}) $display("FAIL rx_setup: got %b/%0d exp 1/1", InstrValid, RetireCount); else pass_cnt++;
      ExecDone = 1;
      #1;
      Reset_L = 0;
      #1;
      total++; if (CurrentPC !== 64'h0) $display("FAIL rx_pc: got %h exp %h", CurrentPC, 64'h0); else pass_cnt++;
      total++; if (RetireCount !== 32'd0) $display("FAIL rx_rc: got %0d exp %0d", RetireCount, 0); else pass_cnt++;
      total++; if (InstrValid !== 1'b0) $display("FAIL rx_valid: got %b exp %b", InstrValid, 1'b0); else pass_cnt++;
      @(negedge CLK);
      ExecDone = 0; Reset_L = 1;
      #1;
      total++; if ({IMemReq, IMemAddr} !== {1'b1, 64'h0}) $display("FAIL rx_resume: got %b/%h exp 1/0", IMemReq, IMemAddr); else pass_cnt++;
      do_fetch(32'h3); do_exec(0, 0, 0, 64'h0, 0);
      total++; if ({CurrentPC, RetireCount} !== {64'h4, 32'd1}) $display("FAIL rx_after: got %h/%0d exp 4/1", CurrentPC, RetireCount); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_ignore();
      test_cond_branch();
      test_uncond_branch();
      test_timeout();
      test_halt();
      test_reset_exec();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0: the CurrentPC value loaded on reset.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255: the number of consecutive un-acknowledged FETCH cycles that triggers a fault.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports, clock and reset first:
- CLK  in  1  clock; all state changes on rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- IMemReq  out  1  instruction fetch request.
- IMemAddr  out  64  fetch address; equals CurrentPC.
- IMemAck  in  1  memory accepted the request; IMemData valid this cycle.
- IMemData  in  32  instruction word.
- Instruction  out  32  latched instruction.
- InstrValid  out  1  Instruction is valid and awaiting execution.
- ExecDone  in  1  execute stage finished the current instruction.
- Branch  in  1  conditional branch.
- Uncondbranch  in  1  unconditional branch.
- ALUZero  in  1  ALU zero flag.
- SignExtImm64  in  64  sign-extended word offset.
- Halt  in  1  stop after the current instruction.
- CurrentPC  out  64  program counter.
- Halted  out  1  block is in the HALTED state.
- Fault  out  1  block is in the FAULT state.
- RetireCount  out  32  count of retired instructions.

Function
REQ-005 The FSM SHALL have states FETCH, EXEC, HALTED and FAULT; all outputs SHALL be registered or decoded from state only.
REQ-006 In FETCH with CurrentPC[1:0] != 0, the next state SHALL be FAULT, and IMemReq SHALL be 0 in that cycle.
REQ-007 In FETCH with an aligned PC, IMemReq SHALL be 1 and IMemAddr SHALL equal CurrentPC.
REQ-008 In FETCH, when IMemAck=1 is sampled: Instruction SHALL load IMemData, the timeout counter SHALL clear, and the next state SHALL be EXEC, giving InstrValid=1 on the following cycle; fetch latency SHALL be 1 cycle after the ack.
REQ-009 In FETCH, each cycle without an ack SHALL increment the timeout counter; when the counter reaches ACK_TIMEOUT, the next state SHALL be FAULT.
REQ-010 InstrValid SHALL be 1 only in EXEC, and IMemReq SHALL be 1 only in FETCH.
REQ-011 In EXEC, ExecDone=1 SHALL update CurrentPC to NextPC, increment RetireCount, and move to HALTED if Halt=1, otherwise to FETCH.
REQ-012 A branch SHALL be taken when Uncondbranch | (Branch & ALUZero).
REQ-013 NextPC SHALL be CurrentPC + (SignExtImm64 << 2) if the branch is taken, else CurrentPC + 4; all arithmetic SHALL be modulo 2^64 with wrap and no flag.
REQ-014 RetireCount SHALL wrap from 32'hFFFFFFFF to 0.
REQ-015 Branch, Uncondbranch, ALUZero, SignExtImm64 and Halt SHALL be sampled only in EXEC together with ExecDone=1.
REQ-016 IMemAck outside FETCH and ExecDone outside EXEC SHALL be ignored.
REQ-017 HALTED and FAULT SHALL be terminal until reset: CurrentPC and RetireCount hold, and IMemReq=0, InstrValid=0.
REQ-018 Halted SHALL be 1 only in HALTED, and Fault SHALL be 1 only in FAULT.

Reset
REQ-019 Reset_L=0 SHALL immediately, without a clock edge, force: state FETCH, CurrentPC=RESET_PC, RetireCount=0, Instruction=0, timeout counter 0, InstrValid=0, Halted=0, Fault=0.
REQ-020 Reset asserted mid-fetch or mid-EXEC SHALL abort the operation with no PC update or retire count increment.
REQ-021 The first IMemReq after reset deassertion SHALL occur in the first clock cycle after release.

Verification
REQ-022 The bench SHALL cover sequential fetch: RESET_PC=0, ack on the first cycle, ExecDone with no branch, three times -> IMemAddr 0, 4, 8, 12 in turn; RetireCount=3.
REQ-023 The bench SHALL cover a taken conditional branch: PC=0x100, Branch=1, ALUZero=1, SignExtImm64=-4 -> CurrentPC=0xF0; with ALUZero=0 instead -> CurrentPC=0x104.
REQ-024 The bench SHALL cover an unconditional branch: PC=0x20, Uncondbranch=1, ALUZero=0, SignExtImm64=3 -> CurrentPC=0x2C.
REQ-025 The bench SHALL cover timeout: ACK_TIMEOUT=4 with IMemAck held 0 -> Fault=1 after 4 FETCH cycles, IMemReq=0, and PC unchanged.
REQ-026 The bench SHALL cover halt and misalignment: Halt=1 with ExecDone at PC=0x8 -> Halted=1, CurrentPC=0xC, no further IMemReq; RESET_PC=2 -> Fault=1 on the first cycle, with no request issued.
REQ-027 The bench SHALL cover reset during EXEC: Reset_L pulsed low with ExecDone=1 -> CurrentPC=RESET_PC, RetireCount=0, and FETCH resumes.
